// File: rtl/aes_pkg.sv
// Shared AES types, round constants and word helpers for the key schedule and cipher datapath.
package aes_pkg;

    typedef logic [0:31]  word_t;
    typedef logic [0:127] key128_t;

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic word_t rot_word(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    // Rcon(r) placed in the most significant byte; zero outside rounds 1..10.
    function automatic word_t rcon_word(input logic [3:0] r);
        word_t w;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            if (r == 4'(i + 1)) w[0:7] = RCON[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the inverse key schedule and its consumer.
// check_key/key_match exist only when INV_KEY_CHECK_EN is defined.
interface aes_inv_key_schedule_if;
    import aes_pkg::*;

    logic       start;
    key128_t    last_key;
    logic       busy;
    logic       rk_valid;
    logic       rk_ready;
    key128_t    rk;
    logic [3:0] rk_round;
    logic       done;
`ifdef INV_KEY_CHECK_EN
    key128_t    check_key;
    logic       key_match;

    modport master (
        output start, last_key, rk_ready, check_key,
        input  busy, rk_valid, rk, rk_round, done, key_match
    );
    modport slave (
        input  start, last_key, rk_ready, check_key,
        output busy, rk_valid, rk, rk_round, done, key_match
    );
`else
    modport master (
        output start, last_key, rk_ready,
        input  busy, rk_valid, rk, rk_round, done
    );
    modport slave (
        input  start, last_key, rk_ready,
        output busy, rk_valid, rk, rk_round, done
    );
`endif

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[{din, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: emits round keys NR..0 from the final round key, one per handshake.
// Optional round-0 key comparison is built when INV_KEY_CHECK_EN is defined.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input logic                    clk,
    input logic                    rst,
    aes_inv_key_schedule_if.slave  bus
);

    if (NK != 4) begin : g_bad_nk
        $error("aes_inv_key_schedule: only NK=4 (AES-128) is supported");
    end
    if (NR != NK + 6) begin : g_bad_nr
        $error("aes_inv_key_schedule: NR must equal NK+6");
    end

    state_t     state_q, state_d;
    key128_t    key_q, key_d;
    logic [3:0] round_q, round_d;
    logic       done_q, done_d;

    word_t   wa, wb, wc, wd;
    word_t   na, nb, nc, nd;
    word_t   rot_w, sub_w;
    key128_t prev_key;

    assign wa = key_q[0:31];
    assign wb = key_q[32:63];
    assign wc = key_q[64:95];
    assign wd = key_q[96:127];

    // Undo the forward recurrence; nd is the previous round's last word, which feeds SubWord.
    assign nd    = wd ^ wc;
    assign nc    = wc ^ wb;
    assign nb    = wb ^ wa;
    assign rot_w = rot_word(nd);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_w[8*i +: 8]),
            .dout (sub_w[8*i +: 8])
        );
    end

    assign na       = wa ^ sub_w ^ rcon_word(round_q);
    assign prev_key = {na, nb, nc, nd};

`ifdef INV_KEY_CHECK_EN
    key128_t check_q, check_d;
    logic    match_q, match_d;
`endif

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
`ifdef INV_KEY_CHECK_EN
        check_d = check_q;
        match_d = match_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    key_d   = bus.last_key;
                    round_d = 4'(NR);
                    state_d = EMIT;
`ifdef INV_KEY_CHECK_EN
                    check_d = bus.check_key;
                    match_d = 1'b0;
`endif
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef INV_KEY_CHECK_EN
                        match_d = (key_q == check_q);
`endif
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
`ifdef INV_KEY_CHECK_EN
            check_q <= '0;
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
`ifdef INV_KEY_CHECK_EN
            check_q <= check_d;
            match_q <= match_d;
`endif
        end
    end

    assign bus.rk       = key_q;
    assign bus.rk_round = round_q;
    assign bus.rk_valid = (state_q == EMIT);
    assign bus.busy     = (state_q == EMIT);
    assign bus.done     = done_q;
`ifdef INV_KEY_CHECK_EN
    assign bus.key_match = match_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule using FIPS-197 round keys and a scoreboard queue.
module tb_aes_inv_key_schedule;
    import aes_pkg::*;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_inv_key_schedule_if bus ();

    aes_inv_key_schedule #(.NK(4), .NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [11];
    vec_t exp_q [$];
    logic exp_match;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [127:0] k, input logic [127:0] ck);
        bus.start    = 1'b1;
        bus.last_key = k;
`ifdef INV_KEY_CHECK_EN
        bus.check_key = ck;
`else
        if (ck === 'x) $display("check key unused");
`endif
        for (int i = 0; i < 11; i++) exp_q.push_back(vecs[i]);
        tick();
        bus.start = 1'b0;
        chk("start_latency_valid", bus.rk_valid, 1);
        chk("start_latency_round", bus.rk_round, 10);
    endtask

    task automatic run_seq(input bit rnd, input int max_hs, input bit poke,
                           output int hs, output int cycles);
        vec_t v;
        logic rdy;
        hs     = 0;
        cycles = 0;
        while (exp_q.size() > 0 && hs < max_hs && cycles < 400) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rk_ready = rdy;
            bus.start    = (poke && cycles == 3);
            if (poke && cycles == 3) bus.last_key = ~vecs[0].key;
            chk("emit_valid", bus.rk_valid, 1);
            chk("emit_busy", bus.busy, 1);
            chk("emit_no_done", bus.done, 0);
            if (rdy) begin
                v = exp_q.pop_front();
                hs++;
                chk("rk_round", bus.rk_round, v.round);
                chk("rk", bus.rk, v.key);
            end
            tick();
            cycles++;
            bus.start = 1'b0;
            if (!rdy) begin
                chk("stall_round", bus.rk_round, exp_q[0].round);
                chk("stall_rk", bus.rk, exp_q[0].key);
            end
        end
        bus.rk_ready = 1'b0;
        if (cycles >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL seq_timeout: got %0d handshakes expected %0d", hs, max_hs);
        end
        if (exp_q.size() == 0) begin
            chk("done_pulse", bus.done, 1);
            chk("idle_busy", bus.busy, 0);
            chk("idle_valid", bus.rk_valid, 0);
`ifdef INV_KEY_CHECK_EN
            chk("key_match", bus.key_match, exp_match);
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs, cyc;
        vecs[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        bus.start    = 1'b0;
        bus.last_key = '0;
        bus.rk_ready = 1'b0;
`ifdef INV_KEY_CHECK_EN
        bus.check_key = '0;
`endif
        exp_match = 1'b1;
        tick();
        tick();
        chk("reset_valid", bus.rk_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_rk", bus.rk, 0);
        chk("reset_round", bus.rk_round, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b0;
        tick();

        // FIPS-197 sequence with the consumer always ready.
        exp_match = 1'b1;
        start_seq(vecs[0].key, vecs[10].key);
        run_seq(1'b0, 11, 1'b0, hs, cyc);
        chk("fips_handshakes", 128'(hs), 11);
        chk("fips_cycles", 128'(cyc), 11);
        tick();
        chk("done_single", bus.done, 0);

        // Random backpressure; check key has one bit flipped.
        exp_match = 1'b0;
        start_seq(vecs[0].key, vecs[10].key ^ (128'h1 << 77));
        run_seq(1'b1, 100, 1'b0, hs, cyc);
        chk("bp_handshakes", 128'(hs), 11);
        tick();
        chk("bp_done_single", bus.done, 0);

        // start with a different key while busy must be ignored.
        exp_match = 1'b1;
        start_seq(vecs[0].key, vecs[10].key);
        run_seq(1'b0, 11, 1'b1, hs, cyc);
        chk("ignore_handshakes", 128'(hs), 11);
        tick();

        // Reset right after the round-5 handshake.
        start_seq(vecs[0].key, vecs[10].key);
        run_seq(1'b0, 6, 1'b0, hs, cyc);
        chk("partial_handshakes", 128'(hs), 6);
        rst = 1'b1;
        tick();
        chk("midrst_valid", bus.rk_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_rk", bus.rk, 0);
        chk("midrst_done", bus.done, 0);
`ifdef INV_KEY_CHECK_EN
        chk("midrst_match", bus.key_match, 0);
`endif
        rst = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_no_done", bus.done, 0);

        // Fresh start, then a back-to-back start in the done cycle.
        exp_match = 1'b1;
        start_seq(vecs[0].key, vecs[10].key);
        run_seq(1'b0, 11, 1'b0, hs, cyc);
        chk("fresh_handshakes", 128'(hs), 11);
        start_seq(vecs[0].key, vecs[10].key);
        run_seq(1'b0, 11, 1'b0, hs, cyc);
        chk("b2b_handshakes", 128'(hs), 11);
        tick();
        chk("b2b_done_single", bus.done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Sequential reverse AES-128 key schedule for the decryption datapath.
- Takes the final round key (round NR) and regenerates the round keys in descending order, NR down to 0, one per handshake. The inverse cipher consumes them in this order.
- Avoids storing all 11 round keys: state is one 128-bit key register plus a round counter.

Parameters:
- NK, 4, key length in 32-bit words. Only 4 (AES-128) is legal; elaboration error otherwise.
- NR, 10, number of rounds. Must equal NK+6; elaboration error otherwise.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  load last_key and begin a sequence; honoured only in IDLE.
- last_key  in  128 [0:127]  round-NR key; bits 0:31 are word w[4*NR].
- busy  out  1  high whenever state != IDLE.
- rk_valid  out  1  rk/rk_round hold a valid round key.
- rk_ready  in  1  consumer accepts rk this cycle.
- rk  out  128 [0:127]  current round key; bits 0:31 are the lowest-index word.
- rk_round  out  4  round index of rk, NR down to 0.
- done  out  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Reset: state=IDLE; rk=0, rk_round=0, rk_valid=0, busy=0, done=0; key register cleared. Reset mid-sequence abandons it immediately, with no done pulse.
- FSM has two states:
  - IDLE: start=1 → key_reg<=last_key, round<=NR, go to EMIT.
  - EMIT: rk_valid=1. Handshake = rk_valid & rk_ready.
    - Handshake with round==0 → IDLE; done=1 in the next cycle only.
    - Handshake with round>0 → key_reg<=prev(key_reg, round), round<=round-1, stay in EMIT.
- Latency:
  - start sampled at edge t → rk_valid=1 with rk_round=NR after edge t.
  - With rk_ready held high: 11 keys on 11 consecutive cycles; done one cycle after the round-0 handshake.
- prev(k, r), with k=[a,b,c,d] = words w[4r..4r+3]:
  - d' = d^c
  - c' = c^b
  - b' = b^a
  - a' = a ^ SubWord(RotWord(d')) ^ Rcon(r)
  - Result = [a',b',c',d'].
  - RotWord = byte left rotate. SubWord = forward S-box on each byte.
  - Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in the MS byte, zeros below.
- prev is combinational from key_reg; single cycle, no pipeline.
- Backpressure: while rk_valid & !rk_ready, rk and rk_round hold stable.
- start while busy is ignored (no reload). start coincident with rst: reset wins.
- done and start in the same cycle: done pulses and the new sequence loads; both are legal.
- rk, rk_round, rk_valid, done and busy are registered outputs.

Optional Feature:
- Macro: INV_KEY_CHECK_EN.
- When defined:
  - Extra port check_key (in, 128, [0:127]), sampled with start.
  - Extra port key_match (out, 1), reset 0.
  - key_match updates in the same cycle done pulses: 1 iff the round-0 key equals the sampled check_key.
  - key_match holds until the next start or rst.
- When undefined: neither port exists and no compare logic is built.

Decomposition:
- Package aes_pkg holds:
  - typedef word_t (logic [0:31]) and typedef key128_t (logic [0:127]).
  - constant RCON table (10 entries).
  - function rot_word.
  - state enum {IDLE, EMIT}.
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4× for SubWord. Shared later with the cipher datapath.

Test Plan:
- FIPS-197 App. A vector: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 → rk_round 10..0 on consecutive cycles.
  - round 9 = ac7766f319fadc2128d12941575c006e
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - done pulses once, one cycle after the round-0 handshake.
- Backpressure: toggle rk_ready randomly → rk and rk_round stable while stalled; same 11-key sequence; exactly 11 handshakes.
- start asserted during EMIT with a different last_key → ignored; sequence completes with the original keys.
- rst asserted after the round-5 handshake → next cycle rk_valid=0, busy=0, rk=0; no done; a fresh start restarts at round 10.
- Back-to-back: start in the done cycle → new sequence with rk_round=10 on the following cycle.
- INV_KEY_CHECK_EN: check_key=2b7e1516…4f3c → key_match=1. Flip one check_key bit → key_match=0.
